// File: rtl/seq_shifter_pkg.sv
// rtl/seq_shifter_pkg.sv - op codes and FSM state encodings for the sequential shifter
package shifter_pkg;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_ROL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - request/response bundle between the EX stage and seq_shifter
interface seq_shifter_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
);
   logic               start;
   logic [1:0]         op;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   data_in;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;

   modport master (output start, op, shamt, data_in, input busy, done, result);
   modport slave  (input start, op, shamt, data_in, output busy, done, result);
endinterface

// File: rtl/seq_shifter_shift_step.sv
// rtl/seq_shifter_shift_step.sv - combinational single-step shift of a word by k in 0..STEP
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int K_W   = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [1:0]       op_i,
   input  logic [K_W-1:0]   k_i,
   output logic [WIDTH-1:0] data_o
);

   // SRA keeps the sign because the working MSB never changes during an SRA sequence
   always_comb begin
      data_o = data_i;
      case (op_i)
         SH_SLL:  data_o = data_i << k_i;
         SH_SRL:  data_o = data_i >> k_i;
         SH_SRA:  data_o = $unsigned($signed(data_i) >>> k_i);
         SH_ROL:  data_o = (data_i << k_i) | (data_i >> (WIDTH - int'(k_i)));
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter: FSM, remaining-count and working register
module seq_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int STEP    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_shifter_if.slave bus
);

   localparam int K_W = $clog2(STEP + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [1:0]         op_q, op_d;
   logic [K_W-1:0]     k_w;
   logic [WIDTH-1:0]   step_w;
   logic               accept_w;

   always_comb begin
      if (int'(rem_q) < STEP) k_w = K_W'(rem_q);
      else                    k_w = K_W'(STEP);
   end

   shift_step #(.WIDTH(WIDTH), .STEP(STEP), .K_W(K_W)) u_step (
      .data_i (work_q),
      .op_i   (op_q),
      .k_i    (k_w),
      .data_o (step_w)
   );

   assign accept_w = bus.start && (state_q != S_SHIFT);

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      op_d    = op_q;
      case (state_q)
         S_SHIFT: begin
            work_d = step_w;
            rem_d  = rem_q - SHAMT_W'(k_w);
            if (rem_d == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: ;
      endcase
      // accept_w is already false in SHIFT, so this only overrides IDLE/DONE
      if (accept_w) begin
         work_d  = bus.data_in;
         op_d    = bus.op;
         rem_d   = bus.shamt;
         state_d = (bus.shamt == '0) ? S_DONE : S_SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         op_q    <= SH_SLL;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
      end
   end

   assign bus.busy   = (state_q == S_SHIFT);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = work_q;

endmodule
